// File: rtl/mem_port_arbiter_if.sv
// CPU-side (fetch + load/store) and memory-side signals of mem_port_arbiter.
// slave = arbiter view, master = CPU/memory environment view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  logic          err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and load/store (D) ports.
// Define ROUND_ROBIN_EN for alternating priority; otherwise D always beats I.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pick_i, pick_d;
  logic          rd_done;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [DW-1:0] rd_data;

`ifdef ROUND_ROBIN_EN
  logic rr_favour_d;

  // Pointer flips on every grant; it only matters when both ports request together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_favour_d <= 1'b1;
    end else if (bus.i_gnt || bus.d_gnt) begin
      rr_favour_d <= ~rr_favour_d;
    end
  end

  always_comb begin
    pick_d = bus.d_req && (!bus.i_req || rr_favour_d);
    pick_i = bus.i_req && !pick_d;
  end
`else
  always_comb begin
    pick_d = bus.d_req;
    pick_i = bus.i_req && !bus.d_req;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // All outputs are gated by reset so a held request cannot grant while reset is low.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rd_done      = 1'b0;
    rd_data      = '0;
    win_addr     = '0;
    win_wdata    = '0;
    bus.i_gnt    = 1'b0;
    bus.d_gnt    = 1'b0;
    bus.i_rvalid = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rdata  = '0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.err      = 1'b0;

    if (reset) begin
      unique case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (pick_d) begin
            bus.d_gnt   = 1'b1;
            bus.mem_req = 1'b1;
            bus.mem_we  = bus.d_we;
            win_addr    = bus.d_addr;
            win_wdata   = bus.d_wdata;
            if (!bus.d_we) begin
              state_nxt = RD_D;
            end
          end else if (pick_i) begin
            bus.i_gnt   = 1'b1;
            bus.mem_req = 1'b1;
            win_addr    = bus.i_addr;
            state_nxt   = RD_I;
          end
        end

        RD_I, RD_D: begin
          cnt_nxt = cnt + 1'b1;
          // Returned data wins over a timeout landing in the same cycle.
          if (bus.mem_rvalid) begin
            rd_done = 1'b1;
            rd_data = bus.mem_rdata;
          end else if (cnt == CNT_LAST) begin
            rd_done = 1'b1;
            bus.err = 1'b1;
          end
          if (rd_done) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
          if (state == RD_I) begin
            bus.i_rvalid = rd_done;
            bus.i_rdata  = rd_data;
          end else begin
            bus.d_rvalid = rd_done;
            bus.d_rdata  = rd_data;
          end
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    bus.mem_addr  = win_addr;
    bus.mem_wdata = win_wdata;
  end

  a_one_grant : assert property (@(posedge clk) disable iff (!reset)
    !(bus.i_gnt && bus.d_gnt));

  a_err_has_rvalid : assert property (@(posedge clk) disable iff (!reset)
    bus.err |-> (bus.i_rvalid ^ bus.d_rvalid));

endmodule
